// File: rtl/bcd_field_editor_if.sv
// Button/limit/value bundle between the debounced button block, the
// editor and the time/alarm/date target registers.
interface bcd_field_editor_if #(
  parameter int NUM_FIELDS = 3,
  parameter int CUR_W      = 2
);
  logic                    en;
  logic [8*NUM_FIELDS-1:0] load_val;
  logic [8*NUM_FIELDS-1:0] field_min;
  logic [8*NUM_FIELDS-1:0] field_max;
  logic                    bt_up;
  logic                    bt_down;
  logic                    bt_left;
  logic                    bt_right;
  logic                    bt_ok;
  logic [8*NUM_FIELDS-1:0] edit_val;
  logic [CUR_W-1:0]        cursor;
  logic                    commit;
  logic                    dirty;
  logic                    wrap_pulse;
  logic [CUR_W-1:0]        wrap_field;

  modport master (
    output en, load_val, field_min, field_max,
    output bt_up, bt_down, bt_left, bt_right, bt_ok,
    input  edit_val, cursor, commit, dirty, wrap_pulse, wrap_field
  );

  modport slave (
    input  en, load_val, field_min, field_max,
    input  bt_up, bt_down, bt_left, bt_right, bt_ok,
    output edit_val, cursor, commit, dirty, wrap_pulse, wrap_field
  );
endinterface

// File: rtl/bcd_field_editor.sv
// Multi-field two-digit BCD editor: cursor selection, per-field min/max
// with wrap indication, auto-repeat on held up/down, and commit strobe.
module bcd_field_editor #(
  parameter int NUM_FIELDS    = 3,
  parameter int CUR_W         = 2,
  parameter int REPEAT_DELAY  = 50000000,
  parameter int REPEAT_PERIOD = 10000000,
  parameter int CNT_W         = 26
) (
  input logic               clk,
  input logic               reset,
  bcd_field_editor_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EDIT, COMMIT} state_t;

  state_t               state_q, state_n;
  logic [CUR_W-1:0]     cursor_q, cursor_n, cur_next, cur_prev;
  logic [CUR_W-1:0]     wfield_q;
  logic                 dirty_q, dirty_n;
  logic                 wrap_q;
  logic [CNT_W-1:0]     cnt_q, cnt_n, cnt_inc, cnt_lim;
  logic                 phase_q, phase_n;
  logic                 h_up, h_dn, h_l, h_r, h_ok;
  logic                 e_up, e_dn, e_l, e_r, e_ok, mv;
  logic                 load, step_up, step_dn;
  logic [NUM_FIELDS-1:0] wrap_v;

  function automatic logic in_range(input logic [7:0] v, input logic [7:0] mn,
                                    input logic [7:0] mx);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v >= mn) && (v <= mx);
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    return (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    return (v[3:0] == 4'd0) ? {v[7:4] - 4'd1, 4'd9} : {v[7:4], v[3:0] - 4'd1};
  endfunction

  assign e_up = bus.bt_up    & ~h_up;
  assign e_dn = bus.bt_down  & ~h_dn;
  assign e_l  = bus.bt_left  & ~h_l;
  assign e_r  = bus.bt_right & ~h_r;
  assign e_ok = bus.bt_ok    & ~h_ok;
  assign mv   = e_l ^ e_r;

  assign cur_next = (cursor_q == CUR_W'(NUM_FIELDS - 1)) ? '0 : cursor_q + CUR_W'(1);
  assign cur_prev = (cursor_q == '0) ? CUR_W'(NUM_FIELDS - 1) : cursor_q - CUR_W'(1);

  // phase_q=0: waiting out the initial hold delay; 1: in periodic repeat.
  assign cnt_inc = cnt_q + CNT_W'(1);
  assign cnt_lim = phase_q ? CNT_W'(REPEAT_PERIOD) : CNT_W'(REPEAT_DELAY);

  // Next state, cursor, dirty flag, repeat counter and step requests.
  always_comb begin
    state_n  = state_q;
    cursor_n = cursor_q;
    dirty_n  = dirty_q;
    cnt_n    = '0;
    phase_n  = 1'b0;
    load     = 1'b0;
    step_up  = 1'b0;
    step_dn  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.en) begin
          load     = 1'b1;
          cursor_n = '0;
          dirty_n  = 1'b0;
          state_n  = EDIT;
        end
      end
      EDIT: begin
        if (!bus.en) begin
          cursor_n = '0;
          state_n  = IDLE;
        end else begin
          // Both vertical buttons high freezes the value and keeps the counter clear.
          if (!(bus.bt_up && bus.bt_down)) begin
            if (e_up) begin
              step_up = 1'b1;
            end else if (e_dn) begin
              step_dn = 1'b1;
            end else if ((bus.bt_up || bus.bt_down) && !mv) begin
              if (cnt_inc == cnt_lim) begin
                step_up = bus.bt_up;
                step_dn = bus.bt_down;
                phase_n = 1'b1;
              end else begin
                cnt_n   = cnt_inc;
                phase_n = phase_q;
              end
            end
          end
          if (step_up || step_dn) dirty_n = 1'b1;
          if (mv) cursor_n = e_r ? cur_next : cur_prev;
          if (e_ok) state_n = COMMIT;
        end
      end
      COMMIT: begin
        dirty_n = 1'b0;
        state_n = bus.en ? EDIT : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cursor_q <= '0;
      dirty_q  <= 1'b0;
      wrap_q   <= 1'b0;
      wfield_q <= '0;
      cnt_q    <= '0;
      phase_q  <= 1'b0;
    end else begin
      state_q  <= state_n;
      cursor_q <= cursor_n;
      dirty_q  <= dirty_n;
      wrap_q   <= |wrap_v;
      if (|wrap_v) wfield_q <= cursor_q;
      cnt_q    <= cnt_n;
      phase_q  <= phase_n;
    end
  end

  // Button history follows the levels even in reset, so a held button is not an edge.
  always_ff @(posedge clk) begin
    h_up <= bus.bt_up;
    h_dn <= bus.bt_down;
    h_l  <= bus.bt_left;
    h_r  <= bus.bt_right;
    h_ok <= bus.bt_ok;
  end

  for (genvar i = 0; i < NUM_FIELDS; i++) begin : g_field
    localparam int LSB = 8 * (NUM_FIELDS - 1 - i);
    logic [7:0] q, d, mn, mx, ld;
    logic       sel, legal, wrap;

    assign mn    = bus.field_min[LSB +: 8];
    assign mx    = bus.field_max[LSB +: 8];
    assign ld    = bus.load_val[LSB +: 8];
    assign sel   = (cursor_q == CUR_W'(i));
    assign legal = in_range(q, mn, mx);

    // Clamp on load; otherwise step the field under the cursor.
    always_comb begin
      d    = q;
      wrap = 1'b0;
      if (load) begin
        d = in_range(ld, mn, mx) ? ld : mn;
      end else if (sel && step_up) begin
        if (q == mx) begin
          d    = mn;
          wrap = 1'b1;
        end else if (!legal) begin
          d = mn;
        end else begin
          d = bcd_inc(q);
        end
      end else if (sel && step_dn) begin
        if (q == mn) begin
          d    = mx;
          wrap = 1'b1;
        end else if (!legal) begin
          d = mx;
        end else begin
          d = bcd_dec(q);
        end
      end
    end

    // Field value register.
    always_ff @(posedge clk) begin
      if (reset) q <= '0;
      else       q <= d;
    end

    assign bus.edit_val[LSB +: 8] = q;
    assign wrap_v[i]              = wrap;
  end

  assign bus.cursor     = cursor_q;
  assign bus.commit     = (state_q == COMMIT);
  assign bus.dirty      = dirty_q;
  assign bus.wrap_pulse = wrap_q;
  assign bus.wrap_field = wfield_q;

endmodule

// File: tb/tb_bcd_field_editor.sv
// Randomized and directed bench for bcd_field_editor against a decimal-arithmetic reference model.
module tb_bcd_field_editor;
  localparam int NF = 3;
  localparam int CW = 2;
  localparam int RD = 8;
  localparam int RP = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bcd_field_editor_if #(.NUM_FIELDS(NF), .CUR_W(CW)) bus();

  bcd_field_editor #(
    .NUM_FIELDS(NF), .CUR_W(CW), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .CNT_W(4)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef enum {M_IDLE, M_EDIT, M_COMMIT} mode_t;
  mode_t      m_mode;
  logic [7:0] m_val [NF];
  int         m_cur, m_wf, age, due;
  bit         m_dirty, m_wrap;
  bit         hu, hd, hl, hr, ho;
  int         n_cmp = 0;
  int         n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int dec(input logic [7:0] v);
    return int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [7:0] bcd(input int d);
    logic [7:0] r;
    r[7:4] = 4'(d / 10);
    r[3:0] = 4'(d % 10);
    return r;
  endfunction

  function automatic bit legal(input logic [7:0] v, input logic [7:0] mn, input logic [7:0] mx);
    return v[7:4] < 4'd10 && v[3:0] < 4'd10 && dec(v) >= dec(mn) && dec(v) <= dec(mx);
  endfunction

  function automatic logic [7:0] fld(input logic [8*NF-1:0] vec, input int i);
    logic [8*NF-1:0] t;
    t = vec >> (8 * (NF - 1 - i));
    return t[7:0];
  endfunction

  function automatic logic [8*NF-1:0] pack_model();
    logic [8*NF-1:0] p = '0;
    for (int i = 0; i < NF; i++) p = {p[8*NF-9:0], m_val[i]};
    return p;
  endfunction

  // Advance the reference model by one clock using the currently driven inputs.
  task automatic model_clock();
    bit eu, ed, el, er, eo, mv, su, sd;
    logic [7:0] mn, mx, v;
    m_wrap = 1'b0;
    if (reset) begin
      m_mode = M_IDLE;
      for (int i = 0; i < NF; i++) m_val[i] = 8'h00;
      m_cur = 0; m_dirty = 1'b0; m_wf = 0; age = 0; due = RD;
    end else begin
      eu = bus.bt_up && !hu;  ed = bus.bt_down && !hd;
      el = bus.bt_left && !hl; er = bus.bt_right && !hr; eo = bus.bt_ok && !ho;
      su = 1'b0; sd = 1'b0;
      case (m_mode)
        M_IDLE: begin
          age = 0; due = RD;
          if (bus.en) begin
            for (int i = 0; i < NF; i++) begin
              v = fld(bus.load_val, i);
              m_val[i] = legal(v, fld(bus.field_min, i), fld(bus.field_max, i)) ? v : fld(bus.field_min, i);
            end
            m_cur = 0; m_dirty = 1'b0; m_mode = M_EDIT;
          end
        end
        M_EDIT: begin
          if (!bus.en) begin
            m_mode = M_IDLE; m_cur = 0; age = 0; due = RD;
          end else begin
            mv = (el != er);
            if (bus.bt_up && bus.bt_down) begin
              age = 0; due = RD;
            end else if (eu || ed) begin
              su = eu; sd = ed; age = 0; due = RD;
            end else if ((bus.bt_up || bus.bt_down) && !mv) begin
              age++;
              if (age == due) begin
                su = bus.bt_up; sd = bus.bt_down; due += RP;
              end
            end else begin
              age = 0; due = RD;
            end
            if (su || sd) begin
              mn = fld(bus.field_min, m_cur);
              mx = fld(bus.field_max, m_cur);
              v  = m_val[m_cur];
              if (su) begin
                if (v == mx) begin v = mn; m_wrap = 1'b1; end
                else if (!legal(v, mn, mx)) v = mn;
                else v = bcd(dec(v) + 1);
              end else begin
                if (v == mn) begin v = mx; m_wrap = 1'b1; end
                else if (!legal(v, mn, mx)) v = mx;
                else v = bcd(dec(v) - 1);
              end
              m_val[m_cur] = v;
              m_dirty = 1'b1;
              if (m_wrap) m_wf = m_cur;
            end
            if (mv) m_cur = er ? (m_cur + 1) % NF : (m_cur + NF - 1) % NF;
            if (eo) m_mode = M_COMMIT;
          end
        end
        default: begin
          m_dirty = 1'b0; age = 0; due = RD;
          m_mode = bus.en ? M_EDIT : M_IDLE;
        end
      endcase
    end
    hu = bus.bt_up; hd = bus.bt_down; hl = bus.bt_left; hr = bus.bt_right; ho = bus.bt_ok;
  endtask

  task automatic tick();
    model_clock();
    @(posedge clk);
    #1;
    check("edit_val",   32'(bus.edit_val),   32'(pack_model()));
    check("cursor",     32'(bus.cursor),     32'(m_cur));
    check("commit",     32'(bus.commit),     32'(m_mode == M_COMMIT));
    check("dirty",      32'(bus.dirty),      32'(m_dirty));
    check("wrap_pulse", 32'(bus.wrap_pulse), 32'(m_wrap));
    check("wrap_field", 32'(bus.wrap_field), 32'(m_wf));
  endtask

  task automatic set_bt(input bit u, input bit d, input bit l, input bit r, input bit o);
    bus.bt_up = u; bus.bt_down = d; bus.bt_left = l; bus.bt_right = r; bus.bt_ok = o;
  endtask

  // Press for one cycle, then release for one cycle.
  task automatic pulse(input bit u, input bit d, input bit l, input bit r, input bit o);
    set_bt(u, d, l, r, o);
    tick();
    set_bt(0, 0, 0, 0, 0);
    tick();
  endtask

  initial begin
    reset = 1'b1;
    bus.en = 1'b0;
    bus.load_val  = '0;
    bus.field_min = 24'h000000;
    bus.field_max = 24'h235959;
    set_bt(0, 0, 0, 0, 0);
    tick(); tick();
    check("rst_val", 32'(bus.edit_val), 32'h0);
    check("rst_commit", 32'(bus.commit), 32'h0);

    // Load with clamping of the out-of-range middle field.
    reset = 1'b0;
    bus.load_val = 24'h127530;
    bus.en = 1'b1;
    tick();
    check("load_clamp", 32'(bus.edit_val), 32'h120030);
    check("load_cursor", 32'(bus.cursor), 32'h0);
    check("load_dirty", 32'(bus.dirty), 32'h0);

    // Field 1: wrap down from 00, wrap up from 59, BCD carry 09 -> 10.
    pulse(0, 0, 0, 1, 0);
    set_bt(0, 1, 0, 0, 0); tick();
    check("dn_wrap_val", 32'(bus.edit_val), 32'h125930);
    check("dn_wrap_pulse", 32'(bus.wrap_pulse), 32'h1);
    set_bt(0, 0, 0, 0, 0); tick();
    check("wrap_single", 32'(bus.wrap_pulse), 32'h0);
    set_bt(1, 0, 0, 0, 0); tick();
    check("up_wrap_val", 32'(bus.edit_val), 32'h120030);
    check("up_wrap_field", 32'(bus.wrap_field), 32'h1);
    set_bt(0, 0, 0, 0, 0); tick();
    for (int k = 0; k < 9; k++) pulse(1, 0, 0, 0, 0);
    check("at_09", 32'(bus.edit_val), 32'h120930);
    pulse(1, 0, 0, 0, 0);
    check("carry_10", 32'(bus.edit_val), 32'h121030);

    // Cursor wrap in both directions and simultaneous left/right.
    pulse(0, 0, 1, 0, 0);
    pulse(0, 0, 1, 0, 0);
    check("cur_left_wrap", 32'(bus.cursor), 32'h2);
    pulse(0, 0, 0, 1, 0);
    check("cur_right_wrap", 32'(bus.cursor), 32'h0);
    pulse(0, 0, 1, 1, 0);
    check("cur_both", 32'(bus.cursor), 32'h0);

    // Auto-repeat on field 2.
    bus.en = 1'b0; tick();
    bus.load_val = 24'h120000;
    bus.en = 1'b1; tick();
    pulse(0, 0, 1, 0, 0);
    set_bt(1, 0, 0, 0, 0);
    for (int k = 0; k < 20; k++) tick();
    set_bt(0, 0, 0, 0, 0); tick();
    check("repeat_05", 32'(bus.edit_val), 32'h120005);
    set_bt(1, 1, 0, 0, 0);
    for (int k = 0; k < 12; k++) tick();
    set_bt(0, 0, 0, 0, 0); tick();
    check("both_frozen", 32'(bus.edit_val), 32'h120005);

    // 12-hour limits on field 0.
    bus.field_min = 24'h010000;
    bus.field_max = 24'h125959;
    pulse(0, 0, 0, 1, 0);
    set_bt(1, 0, 0, 0, 0); tick();
    check("h12_wrap_val", 32'(bus.edit_val), 32'h010005);
    check("h12_wrap_pulse", 32'(bus.wrap_pulse), 32'h1);
    check("h12_wrap_field", 32'(bus.wrap_field), 32'h0);
    set_bt(0, 0, 0, 0, 0); tick();
    for (int k = 0; k < 10; k++) pulse(1, 0, 0, 0, 0);
    bus.field_max = 24'h095959;
    set_bt(1, 0, 0, 0, 0); tick();
    check("h12_clamp_val", 32'(bus.edit_val), 32'h010005);
    check("h12_clamp_nowrap", 32'(bus.wrap_pulse), 32'h0);
    set_bt(0, 0, 0, 0, 0); tick();
    bus.field_min = 24'h000000;
    bus.field_max = 24'h235959;

    // Commit, abort, and reset racing an ok edge.
    set_bt(0, 0, 0, 0, 1); tick();
    check("commit_pulse", 32'(bus.commit), 32'h1);
    check("commit_dirty", 32'(bus.dirty), 32'h1);
    set_bt(0, 0, 0, 0, 0); tick();
    check("commit_end", 32'(bus.commit), 32'h0);
    check("commit_clean", 32'(bus.dirty), 32'h0);
    pulse(1, 0, 0, 0, 0);
    bus.en = 1'b0; tick();
    check("abort_commit", 32'(bus.commit), 32'h0);
    check("abort_dirty", 32'(bus.dirty), 32'h1);
    pulse(1, 0, 0, 0, 0);
    check("idle_hold", 32'(bus.edit_val), 32'h020005);
    bus.en = 1'b1; tick();
    pulse(1, 0, 0, 0, 0);
    set_bt(0, 0, 0, 0, 1);
    reset = 1'b1; tick();
    check("rst_ok_commit", 32'(bus.commit), 32'h0);
    check("rst_ok_val", 32'(bus.edit_val), 32'h0);
    reset = 1'b0; tick();
    check("held_ok_commit", 32'(bus.commit), 32'h0);
    set_bt(0, 0, 0, 0, 0); tick();

    // Randomized traffic.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 7) == 0) bus.bt_up    = ~bus.bt_up;
      if ($urandom_range(0, 7) == 0) bus.bt_down  = ~bus.bt_down;
      if ($urandom_range(0, 9) == 0) bus.bt_left  = ~bus.bt_left;
      if ($urandom_range(0, 9) == 0) bus.bt_right = ~bus.bt_right;
      if ($urandom_range(0, 15) == 0) bus.bt_ok   = ~bus.bt_ok;
      if ($urandom_range(0, 49) == 0) bus.en      = ~bus.en;
      if ($urandom_range(0, 29) == 0) bus.load_val = 24'($urandom);
      if ($urandom_range(0, 99) == 0) begin
        for (int i = 0; i < NF; i++) begin
          int a, b;
          a = $urandom_range(0, 99);
          b = $urandom_range(0, 99);
          if (a > b) begin int t; t = a; a = b; b = t; end
          bus.field_min[8*(NF-1-i) +: 8] = bcd(a);
          bus.field_max[8*(NF-1-i) +: 8] = bcd(b);
        end
      end
      reset = ($urandom_range(0, 299) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
